serdes_lane_array: RTL and testbench

Multi-lane, half-duplex serialiser/deserialiser for the DDR5 DQ path. It is the parametrised successor of the single-lane serdes. It carries NUM_LANES lanes of WIDTH-bit words and adds:
- a valid/ready write handshake;
- back-to-back streaming;
- a selectable bit order;
- an enforced bus-turnaround gap, with an explicit output enable for the pad tri-state.

It sits between the controller's data-word path and the DQ pad drivers.

---
 rtl/serdes_lane_array.sv | 178 +++++++++++++++++
 tb/tb_serdes_lane_array.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/serdes_lane_array.sv
// Multi-lane DDR5 DQ serialiser/deserialiser with a valid/ready write handshake,
// back-to-back streaming, selectable bit order and an enforced bus-turnaround gap.
module serdes_lane_array #(
  parameter int WIDTH     = 8,
  parameter int NUM_LANES = 4,
  parameter bit MSB_FIRST = 1'b1,
  parameter int TURN_CYC  = 2
) (
  input  logic                           mem_clk,
  input  logic                           rst,
  input  logic                           en,
  input  logic                           dir,
  input  logic [NUM_LANES*WIDTH-1:0]     tx_data,
  input  logic                           tx_valid,
  output logic                           tx_ready,
  output logic [NUM_LANES-1:0]           dq_out,
  output logic                           dq_oe,
  input  logic [NUM_LANES-1:0]           dq_in,
  output logic [NUM_LANES*WIDTH-1:0]     rx_data,
  output logic                           rx_valid,
  output logic                           busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int TW = $clog2(TURN_CYC + 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(WIDTH - 1);
  localparam logic [TW-1:0] TURN_LAST = TW'(TURN_CYC - 1);

  typedef enum logic [1:0] {IDLE, TX, RX, TURN} state_e;

  state_e state_q, state_d;
  logic [CW-1:0] bitCnt_q, bitCnt_d;
  logic [TW-1:0] turnCnt_q, turnCnt_d;
  logic lastDir_q, lastDir_d;
  logic lastDirValid_q, lastDirValid_d;
  logic rxValid_q, rxValid_d;
  logic [NUM_LANES-1:0][WIDTH-1:0] txSh_q, txSh_d;
  logic [NUM_LANES-1:0][WIDTH-1:0] rxSh_q, rxSh_d;
  logic [NUM_LANES-1:0][WIDTH-1:0] rxData_q, rxData_d;
  logic [NUM_LANES-1:0][WIDTH-1:0] txWords, rxNext;
  logic lastBit, accept, needTurnTx, needTurnRx;

  assign txWords    = tx_data;
  assign lastBit    = (bitCnt_q == CNT_LAST);
  // A direction change against the last completed word must pass through TURN first.
  assign needTurnTx = lastDirValid_q & ~lastDir_q;
  assign needTurnRx = lastDirValid_q & lastDir_q;

  assign tx_ready = ~rst & en & dir &
                    (((state_q == IDLE) & ~needTurnTx) | ((state_q == TX) & lastBit));
  assign accept   = tx_valid & tx_ready;

  assign dq_oe    = (state_q == TX);
  assign busy     = (state_q != IDLE);
  assign rx_data  = rxData_q;
  assign rx_valid = rxValid_q;

  always_comb begin
    dq_out = '0;
    rxNext = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (MSB_FIRST) begin
        rxNext[i] = {rxSh_q[i][WIDTH-2:0], dq_in[i]};
        if (state_q == TX) dq_out[i] = txSh_q[i][WIDTH-1];
      end else begin
        rxNext[i] = {dq_in[i], rxSh_q[i][WIDTH-1:1]};
        if (state_q == TX) dq_out[i] = txSh_q[i][0];
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    bitCnt_d       = bitCnt_q;
    turnCnt_d      = turnCnt_q;
    lastDir_d      = lastDir_q;
    lastDirValid_d = lastDirValid_q;
    txSh_d         = txSh_q;
    rxSh_d         = rxSh_q;
    rxData_d       = rxData_q;
    rxValid_d      = 1'b0;

    case (state_q)
      IDLE: begin
        bitCnt_d  = '0;
        turnCnt_d = '0;
        if (en) begin
          if (dir) begin
            if (needTurnTx) begin
              state_d = TURN;
            end else if (accept) begin
              state_d = TX;
              txSh_d  = txWords;
            end
          end else begin
            state_d = needTurnRx ? TURN : RX;
          end
        end
      end

      TX: begin
        if (lastBit) begin
          bitCnt_d       = '0;
          lastDir_d      = 1'b1;
          lastDirValid_d = 1'b1;
          if (accept) begin
            txSh_d = txWords;
          end else if (en & ~dir) begin
            state_d = TURN;
          end else begin
            state_d = IDLE;
          end
        end else begin
          bitCnt_d = bitCnt_q + CW'(1);
          for (int i = 0; i < NUM_LANES; i++) begin
            if (MSB_FIRST) txSh_d[i] = {txSh_q[i][WIDTH-2:0], 1'b0};
            else           txSh_d[i] = {1'b0, txSh_q[i][WIDTH-1:1]};
          end
        end
      end

      RX: begin
        rxSh_d = rxNext;
        if (lastBit) begin
          bitCnt_d       = '0;
          rxData_d       = rxNext;
          rxValid_d      = 1'b1;
          lastDir_d      = 1'b0;
          lastDirValid_d = 1'b1;
          if (en & ~dir)     state_d = RX;
          else if (en & dir) state_d = TURN;
          else               state_d = IDLE;
        end else begin
          bitCnt_d = bitCnt_q + CW'(1);
        end
      end

      TURN: begin
        bitCnt_d = '0;
        // Leaving TURN forgets the history so the new direction starts without another gap.
        if (turnCnt_q == TURN_LAST) begin
          state_d        = IDLE;
          turnCnt_d      = '0;
          lastDirValid_d = 1'b0;
        end else begin
          turnCnt_d = turnCnt_q + TW'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge mem_clk) begin
    if (rst) begin
      state_q        <= IDLE;
      bitCnt_q       <= '0;
      turnCnt_q      <= '0;
      lastDir_q      <= 1'b0;
      lastDirValid_q <= 1'b0;
      rxValid_q      <= 1'b0;
      txSh_q         <= '0;
      rxSh_q         <= '0;
      rxData_q       <= '0;
    end else begin
      state_q        <= state_d;
      bitCnt_q       <= bitCnt_d;
      turnCnt_q      <= turnCnt_d;
      lastDir_q      <= lastDir_d;
      lastDirValid_q <= lastDirValid_d;
      rxValid_q      <= rxValid_d;
      txSh_q         <= txSh_d;
      rxSh_q         <= rxSh_d;
      rxData_q       <= rxData_d;
    end
  end

endmodule

// File: tb/tb_serdes_lane_array.sv
// Directed bench for serdes_lane_array (WIDTH=4, NUM_LANES=2) with a queue scoreboard;
// a second instance with LSB-first ordering receives the same serial stream.
module tb_serdes_lane_array;

  localparam int W = 4;
  localparam int L = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, en, dir, txValid;
  logic [7:0] txData;
  logic [1:0] dqIn;

  logic txReady, dqOe, rxValid, busy;
  logic [1:0] dqOut;
  logic [7:0] rxData;
  logic lTxReady, lDqOe, lRxValid, lBusy;
  logic [1:0] lDqOut;
  logic [7:0] lRxData;

  int testsRun = 0;
  int testsFailed = 0;

  logic [1:0] expDq[$];
  logic [7:0] expRx[$];
  logic [7:0] expRxLsb[$];

  serdes_lane_array #(.WIDTH(W), .NUM_LANES(L), .MSB_FIRST(1'b1), .TURN_CYC(2)) dut (
    .mem_clk(clk), .rst(rst), .en(en), .dir(dir),
    .tx_data(txData), .tx_valid(txValid), .tx_ready(txReady),
    .dq_out(dqOut), .dq_oe(dqOe), .dq_in(dqIn),
    .rx_data(rxData), .rx_valid(rxValid), .busy(busy)
  );

  serdes_lane_array #(.WIDTH(W), .NUM_LANES(L), .MSB_FIRST(1'b0), .TURN_CYC(2)) dutLsb (
    .mem_clk(clk), .rst(rst), .en(en), .dir(dir),
    .tx_data(txData), .tx_valid(txValid), .tx_ready(lTxReady),
    .dq_out(lDqOut), .dq_oe(lDqOe), .dq_in(dqIn),
    .rx_data(lRxData), .rx_valid(lRxValid), .busy(lBusy)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic e, input logic d, input logic v,
                               input logic [7:0] td, input logic [1:0] di);
    rst = r; en = e; dir = d; txValid = v; txData = td; dqIn = di;
    #1;
  endtask

  // Expected dq_out per cycle for an MSB-first word: cycle k carries bit W-1-k of each lane.
  task automatic pushTx(input logic [7:0] word);
    logic [1:0] v;
    for (int k = 0; k < W; k++) begin
      for (int i = 0; i < L; i++) v[i] = word[i*W + (W-1-k)];
      expDq.push_back(v);
    end
  endtask

  // seq[2k +: 2] is the dq_in vector of sample k; builds the word for both bit orders.
  task automatic pushRx(input logic [7:0] seq);
    logic [7:0] m, l;
    m = '0; l = '0;
    for (int k = 0; k < W; k++) begin
      for (int i = 0; i < L; i++) begin
        m[i*W + (W-1-k)] = seq[2*k + i];
        l[i*W + k]       = seq[2*k + i];
      end
    end
    expRx.push_back(m);
    expRxLsb.push_back(l);
  endtask

  task automatic clockEdge();
    logic [1:0] e2;
    logic [7:0] e8;
    @(posedge clk);
    #1;
    if (dqOe) begin
      if (expDq.size() == 0) checkOutput("dq_oe unexpected", 32'(dqOe), 0);
      else begin
        e2 = expDq.pop_front();
        checkOutput("dq_out bit", 32'(dqOut), 32'(e2));
      end
    end else begin
      checkOutput("dq_out idle", 32'(dqOut), 0);
    end
    if (rxValid) begin
      if (expRx.size() == 0) checkOutput("rx_valid unexpected", 32'(rxValid), 0);
      else begin
        e8 = expRx.pop_front();
        checkOutput("rx_data msb", 32'(rxData), 32'(e8));
      end
    end
    if (lRxValid) begin
      if (expRxLsb.size() == 0) checkOutput("lsb rx_valid unexpected", 32'(lRxValid), 0);
      else begin
        e8 = expRxLsb.pop_front();
        checkOutput("rx_data lsb", 32'(lRxData), 32'(e8));
      end
    end
  endtask

  task automatic runRx(input logic [7:0] seq, input logic dropEn);
    for (int k = 0; k < W; k++) begin
      dqIn = seq[2*k +: 2];
      if (k == W-1 && dropEn) en = 1'b0;
      clockEdge();
      checkOutput("rx pulse", 32'(rxValid), 32'(k == W-1));
      checkOutput("rx oe", 32'(dqOe), 0);
    end
  endtask

  initial begin
    applyStimulus(1, 0, 0, 0, 8'h00, 2'b00);
    clockEdge();
    clockEdge();
    checkOutput("reset dq_oe", 32'(dqOe), 0);
    checkOutput("reset dq_out", 32'(dqOut), 0);
    checkOutput("reset rx_data", 32'(rxData), 0);
    checkOutput("reset rx_valid", 32'(rxValid), 0);
    checkOutput("reset tx_ready", 32'(txReady), 0);
    checkOutput("reset busy", 32'(busy), 0);
    checkOutput("reset lsb tx_ready", 32'(lTxReady), 0);
    checkOutput("reset lsb dq_out", 32'(lDqOut), 0);
    checkOutput("reset lsb dq_oe", 32'(lDqOe), 0);
    checkOutput("reset lsb busy", 32'(lBusy), 0);

    // Single write word.
    applyStimulus(0, 1, 1, 1, 8'hA5, 2'b00);
    checkOutput("t1 ready idle", 32'(txReady), 1);
    pushTx(8'hA5);
    clockEdge();
    checkOutput("t1 oe bit0", 32'(dqOe), 1);
    checkOutput("t1 busy", 32'(busy), 1);
    txValid = 1'b0;
    for (int k = 1; k < W; k++) begin
      clockEdge();
      checkOutput("t1 oe", 32'(dqOe), 1);
    end
    clockEdge();
    checkOutput("t1 oe after", 32'(dqOe), 0);
    checkOutput("t1 busy after", 32'(busy), 0);
    checkOutput("t1 bits drained", 32'(expDq.size()), 0);

    // Back-to-back write words.
    applyStimulus(0, 1, 1, 1, 8'hA5, 2'b00);
    pushTx(8'hA5);
    clockEdge();
    txData = 8'h3C;
    for (int k = 0; k < W; k++) begin
      if (k > 0) clockEdge();
      checkOutput("t2 oe", 32'(dqOe), 1);
      checkOutput("t2 ready", 32'(txReady), 32'(k == W-1));
    end
    pushTx(8'h3C);
    clockEdge();
    txValid = 1'b0;
    checkOutput("t2 no gap", 32'(dqOe), 1);
    checkOutput("t2 ready word2", 32'(txReady), 0);
    for (int k = 1; k < W; k++) begin
      clockEdge();
      checkOutput("t2 oe word2", 32'(dqOe), 1);
    end
    clockEdge();
    checkOutput("t2 oe after", 32'(dqOe), 0);
    checkOutput("t2 busy after", 32'(busy), 0);
    checkOutput("t2 bits drained", 32'(expDq.size()), 0);

    // Write-to-read turnaround; dq_in garbage during TURN must be ignored.
    applyStimulus(0, 1, 0, 0, 8'h00, 2'b11);
    clockEdge();
    checkOutput("t4 turn busy", 32'(busy), 1);
    checkOutput("t4 turn oe", 32'(dqOe), 0);
    checkOutput("t4 turn ready", 32'(txReady), 0);
    clockEdge();
    checkOutput("t4 turn busy2", 32'(busy), 1);
    checkOutput("t4 turn oe2", 32'(dqOe), 0);
    clockEdge();
    checkOutput("t4 idle after turn", 32'(busy), 0);
    dqIn = 2'b10;
    clockEdge();
    checkOutput("t4 rx entered", 32'(busy), 1);
    pushRx(8'h07);
    runRx(8'h07, 1'b1);
    checkOutput("t4 lsb nibble", 32'(lRxData[3:0]), 4'h3);
    clockEdge();
    checkOutput("t4 rx hold", 32'(rxData), 8'h8C);
    checkOutput("t4 busy after", 32'(busy), 0);
    checkOutput("t4 rx drained", 32'(expRx.size() + expRxLsb.size()), 0);

    // Fresh reset, two streamed read words.
    applyStimulus(1, 0, 0, 0, 8'h00, 2'b00);
    clockEdge();
    applyStimulus(0, 1, 0, 0, 8'h00, 2'b00);
    checkOutput("t3 rx_data reset", 32'(rxData), 0);
    clockEdge();
    checkOutput("t3 rx entered", 32'(busy), 1);
    pushRx(8'h2D);
    pushRx(8'hD2);
    runRx(8'h2D, 1'b0);
    runRx(8'hD2, 1'b1);
    clockEdge();
    checkOutput("t3 busy after", 32'(busy), 0);
    checkOutput("t3 rx drained", 32'(expRx.size() + expRxLsb.size()), 0);

    // Read-to-write turnaround, then reset in the middle of the word.
    applyStimulus(0, 1, 1, 1, 8'h5A, 2'b00);
    checkOutput("t5 ready turn pending", 32'(txReady), 0);
    clockEdge();
    checkOutput("t5 turn ready", 32'(txReady), 0);
    checkOutput("t5 turn busy", 32'(busy), 1);
    clockEdge();
    checkOutput("t5 turn oe", 32'(dqOe), 0);
    clockEdge();
    checkOutput("t5 ready after turn", 32'(txReady), 1);
    pushTx(8'h5A);
    clockEdge();
    checkOutput("t5 oe bit0", 32'(dqOe), 1);
    txValid = 1'b0;
    clockEdge();
    rst = 1'b1;
    #1;
    clockEdge();
    checkOutput("t5 rst oe", 32'(dqOe), 0);
    checkOutput("t5 rst dq_out", 32'(dqOut), 0);
    checkOutput("t5 rst ready", 32'(txReady), 0);
    checkOutput("t5 rst busy", 32'(busy), 0);
    applyStimulus(0, 0, 1, 0, 8'h00, 2'b00);
    clockEdge();
    clockEdge();
    checkOutput("t5 bits never driven", 32'(expDq.size()), 2);
    expDq.delete();

    // en dropped after the first bit: the word still completes.
    applyStimulus(0, 1, 1, 1, 8'hC3, 2'b00);
    pushTx(8'hC3);
    clockEdge();
    en = 1'b0;
    txValid = 1'b0;
    #1;
    for (int k = 1; k < W; k++) begin
      clockEdge();
      checkOutput("t6 oe", 32'(dqOe), 1);
      checkOutput("t6 ready", 32'(txReady), 0);
    end
    clockEdge();
    checkOutput("t6 busy after", 32'(busy), 0);
    checkOutput("t6 oe after", 32'(dqOe), 0);
    checkOutput("t6 ready en low", 32'(txReady), 0);
    checkOutput("t6 bits drained", 32'(expDq.size()), 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
